reg_writeback: RTL and testbench

Register-writeback stage and architectural register file of the CPU32 pipeline. It sits directly downstream of the memory stage and its pipeline register. It takes the two memory-stage results, the two destination register numbers, the 4-bit writeback op and the condition-test result, then commits up to two register writes per clock. It also serves three combinational read ports to the decode/operand-fetch stage, with same-cycle write bypass.

---
 rtl/reg_writeback.sv | 142 ++++++++++++++
 tb/tb_reg_writeback.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// CPU32 register-writeback stage: dual-port commit into the architectural register file,
// three bypassed combinational read ports. Optional write counter under WB_PERF_CNT_EN.
module reg_writeback #(
  parameter int REGS     = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m1,
  input  logic [31:0] m2,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [3:0]  op,
  input  logic        proceed,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  ra3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3,
  output logic        wb_valid,
  output logic [1:0]  wb_ports
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0] wb_count
`endif
);

  localparam logic [5:0] REGS_LIM = 6'(REGS);

  logic [31:0] regs [REGS];
  logic [3:0]  eop;
  logic        w1_en, w2_en, w1_go, w2_go;
  logic [4:0]  w1_addr, w2_addr;
  logic [31:0] w1_data, w2_data;
  logic [4:0]  ra_vec [3];
  logic [31:0] rd_vec [3];

  function automatic logic in_range(input logic [4:0] addr);
    in_range = ({1'b0, addr} < REGS_LIM);
  endfunction

  function automatic logic dest_ok(input logic [4:0] addr);
    dest_ok = in_range(addr) && !(ZERO_REG && (addr == 5'd0));
  endfunction

  // Decode the effective op into the two write ports (port 1 is the a1-sourced write, a2 for op 5)
  always_comb begin
    eop     = proceed ? op : 4'd0;
    w1_en   = 1'b0;
    w2_en   = 1'b0;
    w1_addr = a1;
    w2_addr = a2;
    w1_data = m1;
    w2_data = m2;
    case (eop)
      4'd1: w1_en = 1'b1;
      4'd2: w2_en = 1'b1;
      4'd3: begin
        w1_en = 1'b1;
        w2_en = 1'b1;
      end
      4'd4: begin
        w1_en   = 1'b1;
        w1_data = m2;
      end
      4'd5: begin
        w1_en   = 1'b1;
        w1_addr = a2;
      end
      4'd6: begin
        w1_en   = 1'b1;
        w2_en   = 1'b1;
        w2_addr = a1 + 5'd1;
      end
      default: begin
        w1_en = 1'b0;
        w2_en = 1'b0;
      end
    endcase
  end

  // Writes are dropped while reset is asserted, which also suppresses the bypass
  assign w1_go = rst & w1_en & dest_ok(w1_addr);
  assign w2_go = rst & w2_en & dest_ok(w2_addr);

  assign ra_vec[0] = ra1;
  assign ra_vec[1] = ra2;
  assign ra_vec[2] = ra3;

  // Read ports with same-cycle bypass; port 2 is checked first so it wins on a collision
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_vec[p] = 32'd0;
      if (w2_go && (w2_addr == ra_vec[p])) begin
        rd_vec[p] = w2_data;
      end else if (w1_go && (w1_addr == ra_vec[p])) begin
        rd_vec[p] = w1_data;
      end else if (!in_range(ra_vec[p]) || (ZERO_REG && (ra_vec[p] == 5'd0))) begin
        rd_vec[p] = 32'd0;
      end else begin
        rd_vec[p] = regs[ra_vec[p]];
      end
    end
  end

  assign rd1 = rd_vec[0];
  assign rd2 = rd_vec[1];
  assign rd3 = rd_vec[2];

  // Register file commit and writeback status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REGS; i++) begin
        regs[i] <= 32'd0;
      end
      wb_valid <= 1'b0;
      wb_ports <= 2'b00;
    end else begin
      if (w1_go) begin
        regs[w1_addr] <= w1_data;
      end
      if (w2_go) begin
        regs[w2_addr] <= w2_data;
      end
      wb_valid <= w1_go | w2_go;
      wb_ports <= {w2_go, w1_go};
    end
  end

`ifdef WB_PERF_CNT_EN
  // Committed-write counter, wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_count <= 32'd0;
    end else begin
      wb_count <= wb_count + {31'd0, w1_go} + {31'd0, w2_go};
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback (default REGS=32, ZERO_REG=1).
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m1, m2;
  logic [4:0]  a1, a2;
  logic [3:0]  op;
  logic        proceed;
  logic [4:0]  ra1, ra2, ra3;
  logic [31:0] rd1, rd2, rd3;
  logic        wb_valid;
  logic [1:0]  wb_ports;
`ifdef WB_PERF_CNT_EN
  logic [31:0] wb_count;
`endif

  int checks = 0;
  int errors = 0;

  reg_writeback dut (
    .clk(clk), .rst(rst), .m1(m1), .m2(m2), .a1(a1), .a2(a2), .op(op),
    .proceed(proceed), .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3), .wb_valid(wb_valid), .wb_ports(wb_ports)
`ifdef WB_PERF_CNT_EN
    , .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; combinational checks follow 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] o, input logic p, input logic [4:0] x1,
                        input logic [4:0] x2, input logic [31:0] d1, input logic [31:0] d2);
    op = o; proceed = p; a1 = x1; a2 = x2; m1 = d1; m2 = d2;
    #1;
  endtask

  task automatic idle();
    op = 4'd0; proceed = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0; ra1 = 5'd5; ra2 = 5'd6; ra3 = 5'd0;
    set_op(4'd3, 1'b1, 5'd5, 5'd6, 32'h1111_1111, 32'h2222_2222);
    check_val("rst_no_bypass", rd1, 32'd0);
    step();
    step();
    rst = 1'b1;
    idle();
    check_val("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_val("rst_wb_ports", {30'd0, wb_ports}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i); ra3 = 5'(i);
      #1;
      check_val("rst_rd1", rd1, 32'd0);
      check_val("rst_rd2", rd2, 32'd0);
      check_val("rst_rd3", rd3, 32'd0);
    end

    // dual write with bypass
    step();
    ra1 = 5'd5; ra2 = 5'd6; ra3 = 5'd7;
    set_op(4'd3, 1'b1, 5'd5, 5'd6, 32'h1111_1111, 32'h2222_2222);
    check_val("dual_byp1", rd1, 32'h1111_1111);
    check_val("dual_byp2", rd2, 32'h2222_2222);
    check_val("dual_rd3", rd3, 32'd0);
    step();
    idle();
    check_val("dual_valid", {31'd0, wb_valid}, 32'd1);
    check_val("dual_ports", {30'd0, wb_ports}, 32'd3);
    check_val("dual_r5", rd1, 32'h1111_1111);
    check_val("dual_r6", rd2, 32'h2222_2222);

    // condition failed
    ra1 = 5'd7;
    set_op(4'd1, 1'b0, 5'd7, 5'd0, 32'hDEAD_BEEF, 32'd0);
    check_val("cond_nobyp", rd1, 32'd0);
    step();
    idle();
    check_val("cond_valid", {31'd0, wb_valid}, 32'd0);
    check_val("cond_ports", {30'd0, wb_ports}, 32'd0);
    check_val("cond_r7", rd1, 32'd0);

    // collision: port 2 wins
    ra1 = 5'd9;
    set_op(4'd3, 1'b1, 5'd9, 5'd9, 32'hAAAA_AAAA, 32'h5555_5555);
    check_val("coll_byp", rd1, 32'h5555_5555);
    step();
    idle();
    check_val("coll_ports", {30'd0, wb_ports}, 32'd3);
    check_val("coll_valid", {31'd0, wb_valid}, 32'd1);
    check_val("coll_r9", rd1, 32'h5555_5555);

    // cross ops and port-2-only op
    ra1 = 5'd10;
    set_op(4'd4, 1'b1, 5'd10, 5'd20, 32'h0000_0033, 32'h0000_0044);
    check_val("op4_byp", rd1, 32'h0000_0044);
    step();
    idle();
    check_val("op4_ports", {30'd0, wb_ports}, 32'd1);
    check_val("op4_r10", rd1, 32'h0000_0044);
    ra2 = 5'd11;
    set_op(4'd5, 1'b1, 5'd21, 5'd11, 32'h0000_0055, 32'h0000_0066);
    check_val("op5_byp", rd2, 32'h0000_0055);
    step();
    idle();
    check_val("op5_ports", {30'd0, wb_ports}, 32'd1);
    check_val("op5_r11", rd2, 32'h0000_0055);
    ra3 = 5'd12;
    set_op(4'd2, 1'b1, 5'd22, 5'd12, 32'h0000_0077, 32'h0000_0088);
    check_val("op2_byp", rd3, 32'h0000_0088);
    step();
    idle();
    check_val("op2_ports", {30'd0, wb_ports}, 32'd2);
    check_val("op2_r12", rd3, 32'h0000_0088);

    // zero register
    ra1 = 5'd0;
    set_op(4'd1, 1'b1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0);
    check_val("zero_nobyp", rd1, 32'd0);
    step();
    idle();
    check_val("zero_valid", {31'd0, wb_valid}, 32'd0);
    check_val("zero_ports", {30'd0, wb_ports}, 32'd0);
    check_val("zero_r0", rd1, 32'd0);

    // pair write wrapping onto register 0
    ra1 = 5'd31; ra2 = 5'd0;
    set_op(4'd6, 1'b1, 5'd31, 5'd3, 32'h0000_0001, 32'h0000_0002);
    check_val("pair_byp31", rd1, 32'h0000_0001);
    check_val("pair_byp0", rd2, 32'd0);
    step();
    idle();
    check_val("pair_ports", {30'd0, wb_ports}, 32'd1);
    check_val("pair_valid", {31'd0, wb_valid}, 32'd1);
    check_val("pair_r31", rd1, 32'h0000_0001);
    check_val("pair_r0", rd2, 32'd0);

    // reserved op
    ra1 = 5'd13;
    set_op(4'd7, 1'b1, 5'd13, 5'd13, 32'h1234_5678, 32'h8765_4321);
    check_val("rsv_nobyp", rd1, 32'd0);
    step();
    idle();
    check_val("rsv_valid", {31'd0, wb_valid}, 32'd0);
    check_val("rsv_r13", rd1, 32'd0);

    // mid-run reset clears the file
    rst = 1'b0;
    ra1 = 5'd5; ra2 = 5'd9;
    step();
    rst = 1'b1;
    idle();
    check_val("rst2_r5", rd1, 32'd0);
    check_val("rst2_r9", rd2, 32'd0);
    check_val("rst2_ports", {30'd0, wb_ports}, 32'd0);
`ifdef WB_PERF_CNT_EN
    check_val("cnt_rst", wb_count, 32'd0);
    set_op(4'd3, 1'b1, 5'd1, 5'd2, 32'h1, 32'h2);
    step();
    set_op(4'd1, 1'b1, 5'd3, 5'd4, 32'h3, 32'h4);
    step();
    set_op(4'd0, 1'b1, 5'd3, 5'd4, 32'h3, 32'h4);
    step();
    set_op(4'd2, 1'b1, 5'd3, 5'd4, 32'h3, 32'h4);
    step();
    set_op(4'd7, 1'b1, 5'd5, 5'd6, 32'h5, 32'h6);
    step();
    idle();
    check_val("cnt_four", wb_count, 32'd4);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check_val("cnt_clear", wb_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
